// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
// uart_tx_cfg
//
// Parametrised UART transmitter. Each accepted word is sent as one frame:
// a start bit, DATA_BITS data bits LSB first, an optional parity bit, and
// STOP_BITS stop bits. Every bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous reset, active-high
//   tx_data   word to send, sampled only on the valid/ready handshake
//   tx_valid  producer has a word
//   tx_ready  transmitter can accept a word (IDLE only)
//   tx_out    serial line, idles high, driven from a flop
//   tx_busy   frame in progress (START..STOP)
//   tx_done   one-cycle pulse in the IDLE cycle that follows the last stop cycle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, ready for a word, counters held at zero
// START  | line low for one bit period
// DATA   | shifting out the latched word, LSB first
// PARITY | one bit period carrying the parity of the latched word
// STOP   | line high for STOP_BITS bit periods
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit                HAS_PAR   = (PARITY != 0);
    localparam bit                ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_n;
    logic [BAUD_W-1:0]     baud_q, baud_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [DATA_BITS-1:0]  shift_q, shift_n;
    logic                  par_q, par_n;
    logic                  line_q, line_n;
    logic                  busy_q;
    logic                  ready_q;
    logic                  done_q, done_n;
    logic                  bit_end;
    logic                  handshake;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign handshake = tx_valid & ready_q;

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        done_n  = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (handshake) begin
                    state_n = S_START;
                    shift_n = tx_data;
                    // parity is frozen with the word so later tx_data changes cannot leak in
                    par_n   = ODD_PAR ? ~(^tx_data) : (^tx_data);
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_STOP;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                // the bit counter is reused to count stop bits
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

    // line level is decoded from the next state so tx_out comes straight from a flop
    always_comb begin
        line_n = 1'b1;
        case (state_n)
            S_START:  line_n = 1'b0;
            S_DATA:   line_n = shift_n[0];
            S_PARITY: line_n = par_n;
            default:  line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            line_q  <= line_n;
            busy_q  <= (state_n != S_IDLE);
            ready_q <= (state_n == S_IDLE);
            done_q  <= done_n;
        end
    end

    assign tx_out   = line_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule
